node_launch_ctrl: RTL and testbench
===================================

Name: node_launch_ctrl

Overview:
- Upstream sequencer for a compiled tree-root wrapper (RST/ST/CLK/RD/RES/IN0/IN1 contract).
- Accepts operand pairs over a valid/ready stream, drives them onto the root's IN0/IN1, issues a one-cycle ST pulse and waits for RD.
- Captures RES into a valid/ready result stream, with a watchdog timeout and a completed-operation counter.

Parameters:
- WIDTH, 16, operand/result width; matches the root's IN0/IN1/RES.
- TIMEOUT, 1023, maximum WAIT cycles before abort; must be at least 2.
- CW, 10, timer width; must satisfy 2^CW > TIMEOUT.

Ports:
- CLK  input  1  single system clock; all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operand pair valid.
- IN_READY  output  1  controller can accept an operand pair.
- IN_A  input  WIDTH  operand for root IN0.
- IN_B  input  WIDTH  operand for root IN1.
- N_ST  output  1  start pulse to the root.
- N_IN0  output  WIDTH  registered operand to the root.
- N_IN1  output  WIDTH  registered operand to the root.
- N_RD  input  1  root ready/done, level.
- N_RES  input  WIDTH  root result.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- OUT_RES  output  WIDTH  captured result.
- OUT_ERR  output  1  result was produced by timeout; OUT_RES=0.
- BUSY  output  1  state is not IDLE.
- OP_CNT  output  16  count of results accepted downstream; wraps 0xFFFF->0.

Behaviour:
- Reset (RST=0, asynchronous, takes effect immediately):
  - State=IDLE.
  - N_ST, OUT_VALID, OUT_ERR, BUSY, OP_CNT, OUT_RES, N_IN0, N_IN1 all 0.
  - IN_READY=1 once reset releases.
  - Reset mid-operation drops N_ST at once and discards any pending result.
- States:
  - IDLE:
    - IN_READY=1.
    - On IN_VALID=1: latch IN_A->N_IN0 and IN_B->N_IN1, then go to START.
  - START:
    - N_ST=1 for exactly this one cycle.
    - Clear the timer.
    - Go to WAIT.
  - WAIT:
    - First WAIT cycle: N_RD is ignored (blanking for stale RD).
    - From the second WAIT cycle on, the first cycle with N_RD=1 latches N_RES->OUT_RES and clears OUT_ERR, then goes to HOLD.
    - The timer increments every WAIT cycle.
    - If the timer equals TIMEOUT and no capture happens that cycle: OUT_RES=0, OUT_ERR=1, go to HOLD.
    - If N_RD=1 and the timeout fall on the same cycle, the capture wins.
  - HOLD:
    - OUT_VALID=1; OUT_RES and OUT_ERR are stable.
    - On OUT_READY=1: go to IDLE, increment OP_CNT (successes and errors alike), drop OUT_VALID the next cycle.
- N_IN0 and N_IN1 hold stable from the accept edge until the next accept. They change only in IDLE on handshake.
- IN_READY=0 in START, WAIT and HOLD. No overlap: exactly one operation in flight.
- OUT_VALID, once high, stays high and keeps its data until OUT_READY=1.
- IN_VALID and OUT_READY have no effect while reset is asserted.
- Latency, with the accept edge at cycle t:
  - N_ST high during cycle t+1.
  - Earliest capture at the end of cycle t+3 (N_RD=1 during t+3).
  - OUT_VALID high from cycle t+4.
  - Back-to-back throughput: one operation per 5 cycles minimum, when OUT_READY is tied high.
- Timeout path: OUT_VALID rises the cycle after the timer reaches TIMEOUT, i.e. TIMEOUT+1 WAIT cycles after the ST cycle.
- Arithmetic:
  - Timer is an unsigned CW-bit counter and saturates at TIMEOUT.
  - OP_CNT is an unsigned 16-bit counter and wraps.

Decomposition:
- Shared package (launch_pkg):
  - state encoding: IDLE=2'd0, START=2'd1, WAIT=2'd2, HOLD=2'd3.
  - default WIDTH=16.
  - default TIMEOUT=1023.
- One sub-module: wait_timer.
  - Ports: clear, enable, expired.
  - Parameters: CW, TIMEOUT.
  - Same clock and asynchronous active-low reset.
- FSM, datapath registers and OP_CNT stay in node_launch_ctrl.

Test Plan:
1. Reset mid-WAIT: RST=0 while in WAIT -> immediately BUSY=0, N_ST=0, OUT_VALID=0, OP_CNT=0; after release, IN_READY=1.
2. Fast root: IN_A=0x1234, IN_B=0x00FF accepted at cycle 0; N_RD=1 with N_RES=0x1333 from cycle 2 -> N_ST high only in cycle 1; the cycle-2 RD is ignored, capture at cycle 3; OUT_VALID=1 at cycle 4 with OUT_RES=0x1333, OUT_ERR=0; OP_CNT=1 after OUT_READY.
3. Slow root with backpressure: N_RD rises 40 cycles after ST, N_RES=0xBEEF; OUT_READY held 0 for 10 cycles -> OUT_RES stays 0xBEEF and OUT_VALID stays 1 for all 10 cycles; IN_READY=0 throughout; IN_VALID pulses during HOLD are ignored.
4. Timeout with TIMEOUT=8: N_RD never rises -> OUT_VALID=1 with OUT_RES=0x0000 and OUT_ERR=1, 9 WAIT cycles after the ST cycle; the next operation completes normally with OUT_ERR=0.
5. Simultaneous events with TIMEOUT=8: N_RD=1 exactly on the cycle the timer hits 8, N_RES=0x0042 -> OUT_RES=0x0042, OUT_ERR=0.
6. Streaming and wrap: preload OP_CNT to 0xFFFE via 2 fewer than 65536 ops (or force), OUT_READY=1 and IN_VALID=1 continuously -> one accept every 5 cycles; OP_CNT goes 0xFFFF then 0x0000; N_IN0/N_IN1 change only on accept edges.

Source files
------------

// File: rtl/launch_pkg.sv
// Shared constants for the tree-root launch controller: FSM encoding and
// default datapath/timeout sizing.
package launch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_TIMEOUT = 1023;
    localparam int unsigned DEF_CW      = 10;

endpackage

// File: rtl/wait_timer.sv
// Saturating watchdog for the WAIT phase: cleared on launch, counts enabled
// cycles and reports when it sits at TIMEOUT.
module wait_timer
    import launch_pkg::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/node_launch_ctrl.sv
// Sequencer in front of a compiled tree root: accepts an operand pair, pulses
// ST, waits for RD (with watchdog) and presents the result downstream.
module node_launch_ctrl
    import launch_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    output logic             N_ST,
    output logic [WIDTH-1:0] N_IN0,
    output logic [WIDTH-1:0] N_IN1,
    input  logic             N_RD,
    input  logic [WIDTH-1:0] N_RES,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_RES,
    output logic             OUT_ERR,
    output logic             BUSY,
    output logic [15:0]      OP_CNT
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] in0_q, in0_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             blank_q, blank_d;
    logic [15:0]      op_cnt_q, op_cnt_d;
    logic             timer_expired;
    logic             rd_seen;

    wait_timer #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RST),
        .clear   (state_q == ST_START),
        .enable  (state_q == ST_WAIT),
        .expired (timer_expired)
    );

    // RD may still be high from the previous operation; ignore it on the first WAIT cycle.
    assign rd_seen = (state_q == ST_WAIT) && !blank_q && N_RD;

    always_comb begin
        state_d  = state_q;
        in0_d    = in0_q;
        in1_d    = in1_q;
        res_d    = res_q;
        err_d    = err_q;
        op_cnt_d = op_cnt_q;
        blank_d  = (state_q == ST_START);
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    in0_d   = IN_A;
                    in1_d   = IN_B;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // A real result beats the watchdog when both land on the same cycle.
                if (rd_seen) begin
                    res_d   = N_RES;
                    err_d   = 1'b0;
                    state_d = ST_HOLD;
                end else if (timer_expired) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (OUT_READY) begin
                    op_cnt_d = op_cnt_q + 16'd1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            in0_q    <= '0;
            in1_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            blank_q  <= 1'b0;
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
            res_q    <= res_d;
            err_q    <= err_d;
            blank_q  <= blank_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign N_ST      = (state_q == ST_START);
    assign OUT_VALID = (state_q == ST_HOLD);
    assign BUSY      = (state_q != ST_IDLE);
    assign N_IN0     = in0_q;
    assign N_IN1     = in1_q;
    assign OUT_RES   = res_q;
    assign OUT_ERR   = err_q;
    assign OP_CNT    = op_cnt_q;

endmodule

// File: tb/tb_node_launch_ctrl.sv
// Bench for node_launch_ctrl: dut_a uses the default watchdog, dut_b uses
// TIMEOUT=8; results are checked by a scoreboard monitor.
module tb_node_launch_ctrl;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        n_rd = 1'b0;
    logic [15:0] n_res = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_n_st, a_out_valid, a_out_err, a_busy;
    logic [15:0] a_n_in0, a_n_in1, a_out_res, a_op_cnt;
    logic        b_in_ready, b_n_st, b_out_valid, b_out_err, b_busy;
    logic [15:0] b_n_in0, b_n_in1, b_out_res, b_op_cnt;

    logic        in_ready, n_st, out_valid, out_err, busy;
    logic [15:0] n_in0, n_in1, out_res, op_cnt;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    node_launch_ctrl dut_a (
        .CLK(clk), .RST(rst_n),
        .IN_VALID(in_valid & ~sel), .IN_READY(a_in_ready),
        .IN_A(in_a), .IN_B(in_b),
        .N_ST(a_n_st), .N_IN0(a_n_in0), .N_IN1(a_n_in1),
        .N_RD(n_rd), .N_RES(n_res),
        .OUT_VALID(a_out_valid), .OUT_READY(out_ready & ~sel),
        .OUT_RES(a_out_res), .OUT_ERR(a_out_err),
        .BUSY(a_busy), .OP_CNT(a_op_cnt)
    );

    node_launch_ctrl #(.WIDTH(16), .TIMEOUT(8), .CW(4)) dut_b (
        .CLK(clk), .RST(rst_n),
        .IN_VALID(in_valid & sel), .IN_READY(b_in_ready),
        .IN_A(in_a), .IN_B(in_b),
        .N_ST(b_n_st), .N_IN0(b_n_in0), .N_IN1(b_n_in1),
        .N_RD(n_rd), .N_RES(n_res),
        .OUT_VALID(b_out_valid), .OUT_READY(out_ready & sel),
        .OUT_RES(b_out_res), .OUT_ERR(b_out_err),
        .BUSY(b_busy), .OP_CNT(b_op_cnt)
    );

    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign n_st      = sel ? b_n_st      : a_n_st;
    assign out_valid = sel ? b_out_valid : a_out_valid;
    assign out_err   = sel ? b_out_err   : a_out_err;
    assign busy      = sel ? b_busy      : a_busy;
    assign n_in0     = sel ? b_n_in0     : a_n_in0;
    assign n_in1     = sel ? b_n_in1     : a_n_in1;
    assign out_res   = sel ? b_out_res   : a_out_res;
    assign op_cnt    = sel ? b_op_cnt    : a_op_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares every result handed downstream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got result 0x%0h err %0b with nothing expected", out_res, out_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_out_res", 32'(out_res), 32'(e.res));
                check("sb_out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand pair in an IDLE cycle; returns at the ST cycle's negedge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_err, input bit push);
        exp_t e;
        step();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        n_rd = 1'b0;
        @(negedge clk);
        check("launch_in_ready", 32'(in_ready), 32'd1);
        if (push) begin
            e.res = exp_res;
            e.err = exp_err;
            sb_q.push_back(e);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("launch_n_st", 32'(n_st), 32'd1);
        check("launch_busy_in_ready", {30'd0, busy, in_ready}, 32'd2);
        check("launch_n_in", {n_in0, n_in1}, {a, b});
    endtask

    // k counts cycles after the ST cycle; RD rises at k==rd_at (never when rd_at<0).
    task automatic wait_valid(input int max_k, input int rd_at, input logic [15:0] res,
                              output int k_seen);
        k_seen = -1;
        for (int k = 1; k <= max_k; k++) begin
            step();
            if (k == rd_at) begin
                n_rd = 1'b1;
                n_res = res;
            end
            @(negedge clk);
            if (k == 1) check("n_st_single_cycle", 32'(n_st), 32'd0);
            if (out_valid) begin
                k_seen = k;
                break;
            end
        end
    endtask

    task automatic accept_result();
        step();
        n_rd = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("accept_out_valid", 32'(out_valid), 32'd1);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("accept_valid_dropped", 32'(out_valid), 32'd0);
        check("accept_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int k;
        int last_acc;
        logic [15:0] exp_cnt, exp_in0, exp_in1;
        exp_t e;

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_n_st", 32'(n_st), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_n_in", {n_in0, n_in1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Fast root: RD high from cycle 2, blanked, captured at cycle 3, valid at cycle 4
        launch(16'h1234, 16'h00FF, 16'h1333, 1'b0, 1'b1);
        wait_valid(10, 1, 16'h1333, k);
        check("fast_valid_cycle", 32'(k), 32'd3);
        check("fast_out_res", 32'(out_res), 32'h1333);
        check("fast_out_err", 32'(out_err), 32'd0);
        accept_result();
        check("fast_op_cnt", 32'(op_cnt), 32'd1);

        // Reset in the middle of WAIT discards the operation
        launch(16'h5555, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        check("midwait_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwait_busy", 32'(busy), 32'd0);
        check("midwait_n_st", 32'(n_st), 32'd0);
        check("midwait_out_valid", 32'(out_valid), 32'd0);
        check("midwait_op_cnt", 32'(op_cnt), 32'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("in_reset_ignores_inputs", {15'd0, busy, n_in0}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("midwait_release_ready", {30'd0, in_ready, busy}, 32'd2);

        // Slow root with backpressure; IN_VALID pulses in HOLD are ignored
        launch(16'h0001, 16'h0002, 16'hBEEF, 1'b0, 1'b1);
        wait_valid(60, 40, 16'hBEEF, k);
        check("slow_valid_cycle", 32'(k), 32'd41);
        for (int i = 0; i < 10; i++) begin
            step();
            in_valid = i[0];
            in_a = 16'hFFFF;
            in_b = 16'hFFFF;
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, 14'd0, out_res}, {2'b10, 14'd0, 16'hBEEF});
            check("bp_n_in0", 32'(n_in0), 32'h0001);
        end
        in_valid = 1'b0;
        accept_result();
        check("slow_op_cnt", 32'(op_cnt), 32'd1);
        check("slow_idle", 32'(busy), 32'd0);

        // Streaming across the OP_CNT wrap with OUT_READY and IN_VALID held high
        @(negedge clk);
        force dut_a.op_cnt_q = 16'hFFFE;
        step();
        release dut_a.op_cnt_q;
        @(negedge clk);
        check("preload_op_cnt", 32'(op_cnt), 32'hFFFE);
        exp_cnt = 16'hFFFE;
        exp_in0 = 16'h0001;
        exp_in1 = 16'h0002;
        last_acc = -1;
        for (int c = 0; c < 22; c++) begin
            step();
            in_valid = (c <= 20);
            in_a = 16'h1000 + 16'(c);
            in_b = 16'h0F0F ^ 16'(c * 3);
            out_ready = 1'b1;
            n_rd = 1'b1;
            n_res = exp_in0 ^ exp_in1;
            @(negedge clk);
            check("stream_op_cnt", 32'(op_cnt), 32'(exp_cnt));
            check("stream_n_in", {n_in0, n_in1}, {exp_in0, exp_in1});
            if (out_valid) exp_cnt = exp_cnt + 16'd1;
            if (in_ready && in_valid) begin
                if (last_acc >= 0) check("stream_accept_period", 32'(c - last_acc), 32'd5);
                last_acc = c;
                e.res = in_a ^ in_b;
                e.err = 1'b0;
                sb_q.push_back(e);
                exp_in0 = in_a;
                exp_in1 = in_b;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && busy; i++) begin
            step();
            n_res = exp_in0 ^ exp_in1;
            @(negedge clk);
        end
        step();
        out_ready = 1'b0;
        n_rd = 1'b0;
        @(negedge clk);
        check("stream_drained", 32'(busy), 32'd0);
        check("stream_final_op_cnt", 32'(op_cnt), 32'h0003);

        // Timeout with TIMEOUT=8, then a normal operation
        sel = 1'b1;
        launch(16'h0A0A, 16'h0505, 16'h0000, 1'b1, 1'b1);
        wait_valid(20, -1, 16'h0000, k);
        check("timeout_valid_cycle", 32'(k), 32'd10);
        check("timeout_out", {15'd0, out_err, out_res}, {15'd0, 1'b1, 16'h0000});
        accept_result();
        launch(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b1);
        wait_valid(20, 2, 16'h0003, k);
        check("after_timeout_valid_cycle", 32'(k), 32'd3);
        check("after_timeout_err", 32'(out_err), 32'd0);
        accept_result();

        // RD arrives on the very cycle the timer reaches 8: capture wins
        launch(16'h0040, 16'h0002, 16'h0042, 1'b0, 1'b1);
        wait_valid(20, 9, 16'h0042, k);
        check("simul_valid_cycle", 32'(k), 32'd10);
        check("simul_out", {15'd0, out_err, out_res}, {15'd0, 1'b0, 16'h0042});
        accept_result();
        check("b_op_cnt", 32'(op_cnt), 32'd3);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
